fft_bin_serializer: RTL and testbench
=====================================

FFT_BIN_SERIALIZER -- requirements
Module: fft_bin_serializer

Interface
REQ-001 Parameter C_AXIS_TIN_WIDTH, default 512, SHALL be the input frame width (8 bins x 64 bits).
REQ-002 Parameter C_AXIS_TOUT_WIDTH, default 64, SHALL be the output beat width (one complex bin).
REQ-003 s_axis_aclk  input  1  SHALL be the single clock; all state on rising edge.
REQ-004 s_axis_areset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 s_axis_tvalid  input  1  SHALL flag a valid input frame.
REQ-006 s_axis_tready  output  1  SHALL flag that the block accepts a frame this cycle.
REQ-007 s_axis_tdata  input  512  SHALL carry bin k at bits [64k+63:64k], real in the upper 32 bits and imag in the lower 32 bits, both signed.
REQ-008 m_axis_tvalid  output  1  SHALL flag a valid output beat.
REQ-009 m_axis_tready  input  1  SHALL be the downstream accept.
REQ-010 m_axis_tdata  output  64  SHALL be {real[31:0], imag[31:0]} of the current bin, unmodified.
REQ-011 m_axis_tuser  output  3  SHALL be the current bin index, 0..7.
REQ-012 m_axis_tlast  output  1  SHALL be high exactly on the bin-7 beat.

Function
REQ-013 The block SHALL hold two frame slots: ACTIVE (being emitted) and PENDING, each with a valid flag.
REQ-014 s_axis_tready SHALL equal NOT pending_valid and SHALL be low while reset is asserted.
REQ-015 An input handshake SHALL load ACTIVE when ACTIVE is empty or is completing its bin-7 handshake in the same cycle; otherwise it SHALL load PENDING.
REQ-016 m_axis_tvalid SHALL equal active_valid; the first beat of a frame SHALL appear the cycle after acceptance (latency 1).
REQ-017 The bin counter SHALL advance by 1 only on an output handshake; it SHALL not change while m_axis_tvalid and not m_axis_tready, and m_axis_tdata/tuser/tlast SHALL then stay stable.
REQ-018 On the bin-7 handshake the counter SHALL wrap to 0; ACTIVE SHALL take PENDING if pending_valid (PENDING cleared), else take a same-cycle input, else become empty.
REQ-019 Back-to-back frames SHALL be emitted with no idle cycle between bin 7 and the next bin 0 when the next frame is already buffered or arrives on the bin-7 handshake cycle.
REQ-020 Sustained throughput SHALL be one beat per cycle (one frame per 8 cycles) with m_axis_tready held high.
REQ-021 Frame order SHALL be preserved; no frame SHALL be dropped or duplicated.
REQ-022 No arithmetic SHALL be applied; data SHALL pass bit-exact.

Reset
REQ-023 Reset SHALL clear both valid flags, the bin counter to 0, and the frame slots to 0, asynchronously.
REQ-024 During and after reset until the first frame: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0.
REQ-025 Reset mid-frame SHALL discard ACTIVE and PENDING; the first frame after release SHALL start at bin 0.

Structure
REQ-026 A shared package fft_pkg SHALL hold N_BINS=8, BIN_WIDTH=64, COMP_WIDTH=32 and the 3-bit bin-index type, shared with the DFT stage.
REQ-027 The two-slot buffer SHALL be one sub-module, axis_frame_buffer2; counter and output mux stay at the top level.

Verification
REQ-028 Impulse frame (every bin real=127, imag=0), m_axis_tready=1 -> 8 beats of 64'h0000007F_00000000, tuser 0..7, tlast only on beat 8, first beat 1 cycle after acceptance.
REQ-029 Frame with bin k = {32'(k+1), -32'(k+1)} -> beat k = {k+1, 2^32-(k+1)}; e.g. beat 2 = 64'h00000003_FFFFFFFD.
REQ-030 Three frames offered continuously, m_axis_tready=1 -> 24 consecutive valid beats without a bubble; s_axis_tready low while PENDING is full.
REQ-031 m_axis_tready toggled 1,0,0,1 during a frame -> tdata/tuser held during stall cycles; counter advances only on handshakes.
REQ-032 s_axis_areset pulsed during beat 4 with PENDING full -> m_axis_tvalid=0 immediately; next accepted frame starts at tuser=0 with its own data.
REQ-033 New frame presented exactly on the bin-7 handshake with PENDING empty -> loaded into ACTIVE, its bin 0 on the next cycle.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT output path (DFT stage and bin serializer).
package fft_pkg;
    localparam int N_BINS      = 8;
    localparam int BIN_WIDTH   = 64;
    localparam int COMP_WIDTH  = 32;
    localparam int FRAME_WIDTH = N_BINS * BIN_WIDTH;

    typedef logic [2:0] bin_idx_t;

    localparam bin_idx_t LAST_BIN = bin_idx_t'(N_BINS - 1);
endpackage

// File: rtl/fft_bin_serializer_if.sv
// AXI-Stream pair around the bin serializer: frame input (s_axis) and per-bin output (m_axis).
interface fft_bin_serializer_if
    import fft_pkg::*;
#(
    parameter int C_AXIS_TIN_WIDTH  = 512,
    parameter int C_AXIS_TOUT_WIDTH = 64
);
    logic                         s_axis_tvalid;
    logic                         s_axis_tready;
    logic [C_AXIS_TIN_WIDTH-1:0]  s_axis_tdata;
    logic                         m_axis_tvalid;
    logic                         m_axis_tready;
    logic [C_AXIS_TOUT_WIDTH-1:0] m_axis_tdata;
    bin_idx_t                     m_axis_tuser;
    logic                         m_axis_tlast;

    // slave: the serializer's own view; master: the surrounding producer/consumer.
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );
endinterface

// File: rtl/axis_frame_buffer2.sv
// Two-slot frame store: HEAD is the frame being emitted, PEND holds the next one.
module axis_frame_buffer2
    import fft_pkg::*;
#(
    parameter int WIDTH = FRAME_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             advance,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);
    logic             pend_valid;
    logic [WIDTH-1:0] pend_data;
    logic             accept;

    assign load_ready = ~pend_valid & ~rst;
    assign accept     = load_valid & load_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid <= 1'b0;
            pend_valid <= 1'b0;
            head_data  <= '0;
            pend_data  <= '0;
        end else if (advance) begin
            // HEAD finishing: refill from PEND first, then from a same-cycle load.
            if (pend_valid) begin
                head_data  <= pend_data;
                pend_valid <= 1'b0;
            end else if (accept) begin
                head_data <= load_data;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!head_valid) begin
                head_data  <= load_data;
                head_valid <= 1'b1;
            end else begin
                pend_data  <= load_data;
                pend_valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/fft_bin_serializer.sv
// Splits each 8-bin FFT frame into one 64-bit beat per bin, tagging bin index and last.
module fft_bin_serializer
    import fft_pkg::*;
#(
    parameter int C_AXIS_TIN_WIDTH  = 512,
    parameter int C_AXIS_TOUT_WIDTH = 64
) (
    input logic                  s_axis_aclk,
    input logic                  s_axis_areset,
    fft_bin_serializer_if.slave  bus
);
    bin_idx_t                    bin;
    logic                        active_valid;
    logic [C_AXIS_TIN_WIDTH-1:0] active_data;
    logic                        out_hs;
    logic                        frame_done;

    assign out_hs     = active_valid & bus.m_axis_tready;
    assign frame_done = out_hs & (bin == LAST_BIN);

    axis_frame_buffer2 #(
        .WIDTH(C_AXIS_TIN_WIDTH)
    ) u_buffer (
        .clk        (s_axis_aclk),
        .rst        (s_axis_areset),
        .load_valid (bus.s_axis_tvalid),
        .load_data  (bus.s_axis_tdata),
        .load_ready (bus.s_axis_tready),
        .advance    (frame_done),
        .head_valid (active_valid),
        .head_data  (active_data)
    );

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            bin <= '0;
        end else if (out_hs) begin
            bin <= frame_done ? '0 : bin + 1'b1;
        end
    end

    assign bus.m_axis_tvalid = active_valid;
    assign bus.m_axis_tdata  = active_data[int'(bin) * C_AXIS_TOUT_WIDTH +: C_AXIS_TOUT_WIDTH];
    assign bus.m_axis_tuser  = bin;
    assign bus.m_axis_tlast  = active_valid & (bin == LAST_BIN);
endmodule

// File: tb/tb_fft_bin_serializer.sv
// Randomized scoreboard bench for fft_bin_serializer: stimulus queues expected beats, monitor checks them.
module tb_fft_bin_serializer;
    import fft_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  user;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fft_bin_serializer_if bus ();

    fft_bin_serializer dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    logic        pat_q[$];
    logic [31:0] cur_re[8];
    logic [31:0] cur_im[8];
    int          n_cmp = 0;
    int          n_err = 0;
    int          streak = 0;
    int          max_streak = 0;
    bit          saw_busy = 0;
    bit          rand_rdy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: scripted pattern first, else random or held high.
    always begin
        @(posedge clk);
        #1;
        if (pat_q.size() != 0) bus.m_axis_tready = pat_q.pop_front();
        else if (rand_rdy)     bus.m_axis_tready = 1'($urandom_range(0, 1));
        else                   bus.m_axis_tready = 1'b1;
    end

    // Monitor: every presented beat must match the oldest expected beat; pop on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.s_axis_tready === 1'b0) saw_busy = 1;
            if (bus.m_axis_tvalid) begin
                streak++;
                if (streak > max_streak) max_streak = streak;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(bus.m_axis_tvalid), 64'd0);
                end else begin
                    check("beat_data", bus.m_axis_tdata, exp_q[0].data);
                    check("beat_user", 64'(bus.m_axis_tuser), 64'(exp_q[0].user));
                    check("beat_last", 64'(bus.m_axis_tlast), 64'(exp_q[0].last));
                    if (bus.m_axis_tready) void'(exp_q.pop_front());
                end
            end else begin
                streak = 0;
                check("idle_tlast", 64'(bus.m_axis_tlast), 64'd0);
            end
        end
    end

    // Offers the frame described by cur_re/cur_im and records its 8 expected beats on acceptance.
    task automatic send_frame();
        logic [511:0] f;
        bit acc;
        int n;
        beat_t b;
        for (int k = 0; k < 8; k++) f[64*k +: 64] = {cur_re[k], cur_im[k]};
        bus.s_axis_tdata  = f;
        bus.s_axis_tvalid = 1'b1;
        acc = 0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = (bus.s_axis_tready === 1'b1);
            if (acc) begin
                for (int k = 0; k < 8; k++) begin
                    b.data = {cur_re[k], cur_im[k]};
                    b.user = 3'(k);
                    b.last = (k == 7);
                    exp_q.push_back(b);
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic rand_frame();
        for (int k = 0; k < 8; k++) begin
            cur_re[k] = $urandom;
            cur_im[k] = $urandom;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_bin(input int k);
        int n = 0;
        while (!(bus.m_axis_tvalid && bus.m_axis_tuser == 3'(k)) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_bin_timeout", 64'(bus.m_axis_tuser), 64'(k));
    endtask

    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.m_axis_tready = 1'b1;
        #1;
        check("rst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_m_tlast",  64'(bus.m_axis_tlast),  64'd0);
        check("rst_m_tuser",  64'(bus.m_axis_tuser),  64'd0);
        check("rst_m_tdata",  bus.m_axis_tdata,       64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_s_tready", 64'(bus.s_axis_tready), 64'd1);
        check("post_rst_m_tdata",  bus.m_axis_tdata,       64'd0);

        // Impulse frame, first beat one cycle after acceptance.
        for (int k = 0; k < 8; k++) begin
            cur_re[k] = 32'd127;
            cur_im[k] = 32'd0;
        end
        send_frame();
        check("impulse_latency_vld", 64'(bus.m_axis_tvalid), 64'd1);
        check("impulse_first_tdata", bus.m_axis_tdata, 64'h0000007F_00000000);
        drain();

        // Ramp frame: bin k = {k+1, -(k+1)}.
        for (int k = 0; k < 8; k++) begin
            cur_re[k] = 32'(k + 1);
            cur_im[k] = -32'(k + 1);
        end
        send_frame();
        wait_bin(2);
        check("ramp_beat2", bus.m_axis_tdata, 64'h00000003_FFFFFFFD);
        drain();

        // Three frames back to back with ready high: no bubble, input stalls on PENDING full.
        max_streak = 0;
        saw_busy = 0;
        for (int i = 0; i < 3; i++) begin
            rand_frame();
            send_frame();
        end
        drain();
        check("burst_no_bubble", 64'(max_streak >= 24), 64'd1);
        check("burst_saw_busy",  64'(saw_busy), 64'd1);

        // Output stalls mid-frame: scoreboard checks the held beat on each stall cycle.
        rand_frame();
        send_frame();
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        drain();

        // New frame arriving on the bin-7 handshake with PENDING empty.
        rand_frame();
        send_frame();
        wait_bin(7);
        rand_frame();
        send_frame();
        check("b7_next_vld",  64'(bus.m_axis_tvalid), 64'd1);
        check("b7_next_user", 64'(bus.m_axis_tuser),  64'd0);
        check("b7_next_data", bus.m_axis_tdata, {cur_re[0], cur_im[0]});
        drain();

        // Reset during beat 4 with PENDING full.
        rand_frame();
        send_frame();
        rand_frame();
        send_frame();
        wait_bin(4);
        #1;
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("midrst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("midrst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        check("midrst_m_tuser",  64'(bus.m_axis_tuser),  64'd0);
        check("midrst_m_tdata",  bus.m_axis_tdata,       64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after_rst_idle", 64'(bus.m_axis_tvalid), 64'd0);
        rand_frame();
        send_frame();
        check("after_rst_vld",  64'(bus.m_axis_tvalid), 64'd1);
        check("after_rst_user", 64'(bus.m_axis_tuser),  64'd0);
        drain();

        // Random traffic with random downstream ready and random gaps.
        rand_rdy = 1;
        for (int i = 0; i < 20; i++) begin
            rand_frame();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_frame();
        end
        drain();
        rand_rdy = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
